// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and width helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } uart_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running bit-rate enable generator
module baud_tick_gen #(
  parameter int CLK_DIV = 104
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLK_DIV-1 forever; frames never restart the phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART byte transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CLK_DIV  = 104,
  parameter int GAP_BITS = 0,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic                 i_tx_busy,
  output logic                 o_baud_tick,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic [IDX_W-1:0]     o_grant_id,
  output logic                 o_busy
);

  // Bit counter must hold both the frame length and the gap length.
  localparam int CNT_MAX = (GAP_BITS > FRAME_BITS) ? GAP_BITS : FRAME_BITS;
  localparam int BIT_W   = $clog2(CNT_MAX + 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] GAP_LAST   = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  // Last grant starts at the top index so requester 0 wins first.
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);

  uart_state_e      state;
  uart_state_e      state_nxt;
  logic             tick;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant;
  logic [7:0]       data_q;
  logic [BIT_W-1:0] bit_cnt;
  logic             grant_valid;
  logic [7:0]       grant_data;
  logic             req_go;

  baud_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  // First valid requester searching upward from the one after the last served.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last) + i) % NUM_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_go = (|i_req_valid) && !i_tx_busy;

  // Mux the granted requester's valid and byte without a variable part-select.
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q == IDX_W'(k)) begin
        grant_valid = i_req_valid[k];
        grant_data  = i_req_data[8*k +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; LOAD only reacts to ticks seen while already in LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_go) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = grant_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD:  if (tick) state_nxt = ST_SEND;
      ST_SEND:  if (tick && bit_cnt == FRAME_LAST) state_nxt = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (tick && bit_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Ready is a one-hot pulse in GRANT only; start rides on a tick seen in LOAD.
  always_comb begin
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    o_busy      = (state != ST_IDLE);
    if (state == ST_GRANT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        o_req_ready[k] = (grant_q == IDX_W'(k));
      end
    end
    if (state == ST_LOAD) begin
      o_tx_start = tick;
    end
  end

  // Grant index, captured byte, fairness pointer and bit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q    <= '0;
      last_grant <= LAST_RST;
      data_q     <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_go) grant_q <= rr_pick(i_req_valid, last_grant);
        end
        ST_GRANT: begin
          if (grant_valid) begin
            data_q     <= grant_data;
            last_grant <= grant_q;
          end
        end
        ST_LOAD: begin
          if (tick) bit_cnt <= '0;
        end
        ST_SEND: begin
          if (tick) bit_cnt <= (bit_cnt == FRAME_LAST) ? '0 : bit_cnt + 1'b1;
        end
        ST_GAP: begin
          if (tick) bit_cnt <= (bit_cnt == GAP_LAST) ? '0 : bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_baud_tick = tick;
  assign o_tx_data   = data_q;
  assign o_grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int CD    = 4;
  localparam int GB    = 0;
  localparam int GB2   = 2;
  localparam int FRAME = 10;
  // Earliest next start: frame, then at least one cycle each of IDLE, GRANT, LOAD.
  localparam int MIN_SP = (FRAME + GB) * CD + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, tx_busy, tick, start, busy;
  logic [3:0]  req_valid, ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic [1:0]  gid;

  logic        rst_g, txbusy_g, tick_g, start_g, busy_g;
  logic [3:0]  valid_g, ready_g;
  logic [31:0] data_g;
  logic [7:0]  txdata_g;
  logic [1:0]  gid_g;

  uart_tx_arbiter #(.NUM_REQ(NR), .CLK_DIV(CD), .GAP_BITS(GB)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(ready), .i_tx_busy(tx_busy), .o_baud_tick(tick), .o_tx_start(start),
    .o_tx_data(tx_data), .o_grant_id(gid), .o_busy(busy)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .CLK_DIV(CD), .GAP_BITS(GB2)) u_dut_gap (
    .i_clk(clk), .i_rst(rst_g), .i_req_valid(valid_g), .i_req_data(data_g),
    .o_req_ready(ready_g), .i_tx_busy(txbusy_g), .o_baud_tick(tick_g), .o_tx_start(start_g),
    .o_tx_data(txdata_g), .o_grant_id(gid_g), .o_busy(busy_g)
  );

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          last_start = -1;
  logic [3:0]  last_ready = '0;
  logic [7:0]  q [NR][$];
  logic [7:0]  mq [NR][$];
  int          acc_ids [$];
  logic [7:0]  st_data [$];
  int          exp_ids [$];
  logic [7:0]  exp_d [$];
  int          m_last = NR - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Each requester presents the head of its queue and holds it until accepted.
  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]        = (q[k].size() != 0);
      req_data[8*k +: 8]  = (q[k].size() != 0) ? q[k][0] : 8'h00;
    end
  endtask

  // Per-cycle observation of the main DUT, sampled mid-cycle.
  task automatic sample();
    if (start) begin
      chk("start_on_tick", tick, 1);
      if (last_start >= 0)
        chk("start_spacing", ((cyc - last_start) >= MIN_SP) && ((cyc - last_start) % CD == 0), 1);
      last_start = cyc;
      st_data.push_back(tx_data);
    end
    if (ready != 0) begin
      chk("ready_onehot", $onehot(ready), 1);
      chk("ready_one_cycle", last_ready, 0);
    end
    last_ready = ready;
  endtask

  // One clock: record the transfer that happened at the edge, refresh drivers, sample.
  task automatic step();
    logic [3:0] xfer;
    @(posedge clk);
    xfer = last_ready & req_valid;
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      if (xfer[k]) begin
        acc_ids.push_back(k);
        if (q[k].size() != 0) void'(q[k].pop_front());
      end
    end
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic reset_a();
    rst = 1'b1;
    for (int k = 0; k < NR; k++) q[k].delete();
    drive();
    step();
    step();
    rst = 1'b0;
    last_start = -1;
    acc_ids.delete();
    st_data.delete();
  endtask

  task automatic run_idle(input int max, input string tag);
    int n;
    n = 0;
    while (!(all_empty() && busy == 1'b0) && n < max) begin
      step();
      n++;
    end
    chk(tag, all_empty() && busy == 1'b0, 1);
  endtask

  // Reference: with every pending requester holding valid, service order is
  // simply the next non-empty requester after the last one served.
  task automatic model_run();
    int k;
    bit any;
    exp_ids.delete();
    exp_d.delete();
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int s = 1; s <= NR; s++) begin
        k = (m_last + s) % NR;
        if (!any && mq[k].size() != 0) begin
          exp_ids.push_back(k);
          exp_d.push_back(mq[k].pop_front());
          m_last = k;
          any = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c0, n_st, nt, nst, nb;
    logic [7:0] b;
    rst = 1'b1; tx_busy = 1'b0; req_valid = '0; req_data = '0;
    rst_g = 1'b1; txbusy_g = 1'b0; valid_g = '0; data_g = '0;

    // Reset values.
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant_id", gid, 0);
    chk("rst_tick", tick, 0);

    // Baud count is 0 in the reset sample, so sample i after release holds count i+1.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("tick_cadence", tick, ((i + 1) % CD) == (CD - 1));
    end

    // Single byte from requester 1.
    q[1].push_back(8'hA5);
    drive();
    n = 0;
    while (ready == 0 && n < 20) begin step(); n++; end
    chk("single_ready", ready, 4'b0010);
    chk("accept_latency", n, 1);
    n = 0;
    while (!start && n < 2 * CD + 4) begin step(); n++; end
    chk("single_start", start, 1);
    chk("single_data", tx_data, 8'hA5);
    c0 = cyc;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk("busy_fall", cyc - c0, (FRAME + GB) * CD + 1);
    chk("single_acc_id", (acc_ids.size() == 1) ? acc_ids[0] : -1, 1);

    // All four valid after reset; requester 0 keeps a second byte pending.
    reset_a();
    for (int k = 0; k < NR; k++) q[k].push_back(8'h10 + 8'(k));
    q[0].push_back(8'h10);
    drive();
    run_idle(600, "all4_done");
    chk("all4_count", st_data.size(), 5);
    for (int i = 0; i < 5; i++) begin
      b = (i == 4) ? 8'h10 : 8'h10 + 8'(i);
      chk("all4_order", (i < st_data.size()) ? st_data[i] : 8'hXX, b);
    end

    // Fairness between requesters 0 and 2.
    reset_a();
    for (int i = 0; i < 3; i++) begin
      q[0].push_back(8'h20 + 8'(i));
      q[2].push_back(8'h40 + 8'(i));
    end
    drive();
    run_idle(600, "fair_done");
    chk("fair_count", acc_ids.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("fair_grant", (i < acc_ids.size()) ? acc_ids[i] : -1, (i % 2 == 0) ? 0 : 2);

    // Withdrawal: requester 3 drops valid in its GRANT cycle while 1 is pending.
    reset_a();
    q[2].push_back(8'h5C);
    drive();
    run_idle(200, "wd_prime_done");
    q[3].push_back(8'h77);
    drive();
    n = 0;
    while (ready == 0 && n < 20) begin step(); n++; end
    chk("wd_grant3", ready, 4'b1000);
    q[3].delete();
    q[1].push_back(8'h6E);
    drive();
    n_st = st_data.size();
    step();
    chk("wd_back_idle", busy, 0);
    chk("wd_data_kept", tx_data, 8'h5C);
    step();
    chk("wd_next_req1", ready, 4'b0010);
    chk("wd_data_kept2", tx_data, 8'h5C);
    run_idle(200, "wd_done");
    chk("wd_one_start", st_data.size(), n_st + 1);
    chk("wd_req1_data", (st_data.size() > n_st) ? st_data[n_st] : 8'hXX, 8'h6E);

    // Busy gate.
    reset_a();
    tx_busy = 1'b1;
    q[0].push_back(8'h3C);
    drive();
    nb = 0;
    repeat (50) begin
      step();
      if (ready != 0) nb++;
    end
    chk("busy_gate_no_ready", nb, 0);
    tx_busy = 1'b0;
    step();
    chk("busy_release_grant", ready, 4'b0001);
    run_idle(200, "busy_done");
    chk("busy_data", (st_data.size() == 1) ? st_data[0] : 8'hXX, 8'h3C);

    // Gap instance: start-to-idle spans frame plus gap.
    rst_g = 1'b0;
    valid_g = 4'b0001;
    data_g[7:0] = 8'hC3;
    n = 0;
    while (ready_g == 0 && n < 20) begin step(); n++; end
    chk("gap_ready", ready_g, 4'b0001);
    step();
    valid_g = '0;
    n = 0;
    while (!start_g && n < 20) begin step(); n++; end
    chk("gap_start_data", {start_g, txdata_g}, {1'b1, 8'hC3});
    c0 = cyc;
    n = 0;
    while (busy_g && n < 200) begin step(); n++; end
    chk("gap_busy_fall", cyc - c0, (FRAME + GB2) * CD + 1);

    // Reset on the 5th tick of a frame in flight.
    valid_g = 4'b0001;
    data_g[7:0] = 8'hD4;
    n = 0;
    while (ready_g == 0 && n < 20) begin step(); n++; end
    step();
    valid_g = '0;
    n = 0;
    while (!start_g && n < 20) begin step(); n++; end
    chk("rst_frame_start", start_g, 1);
    nt = 0;
    n = 0;
    while (nt < 5 && n < 100) begin
      step();
      n++;
      if (tick_g) nt++;
    end
    chk("rst_fifth_tick", nt, 5);
    chk("rst_in_send", busy_g, 1);
    rst_g = 1'b1;
    valid_g = 4'b0101;
    data_g = 32'h00E2_00E0;
    step();
    chk("rst_busy_low", busy_g, 0);
    chk("rst_ready_low", ready_g, 0);
    nst = start_g ? 1 : 0;
    rst_g = 1'b0;
    n = 0;
    while (ready_g == 0 && n < 20) begin
      step();
      n++;
      if (start_g) nst++;
    end
    chk("rst_first_grant", ready_g, 4'b0001);
    chk("rst_no_start", nst, 0);
    valid_g = '0;
    rst_g = 1'b1;

    // Randomised rounds against the reference model, with random busy gating.
    reset_a();
    m_last = NR - 1;
    for (int r = 0; r < 4; r++) begin
      acc_ids.delete();
      st_data.delete();
      for (int k = 0; k < NR; k++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) begin
          b = 8'($urandom);
          q[k].push_back(b);
          mq[k].push_back(b);
        end
      end
      drive();
      model_run();
      n = 0;
      while (!(all_empty() && busy == 1'b0) && n < 1000) begin
        tx_busy = ($urandom_range(0, 3) == 0);
        step();
        n++;
      end
      tx_busy = 1'b0;
      chk("rand_done", all_empty() && busy == 1'b0, 1);
      chk("rand_count", acc_ids.size(), exp_ids.size());
      chk("rand_starts", st_data.size(), exp_d.size());
      for (int i = 0; i < exp_ids.size(); i++) begin
        chk("rand_grant", (i < acc_ids.size()) ? acc_ids[i] : -1, exp_ids[i]);
        chk("rand_data", (i < st_data.size()) ? st_data[i] : 8'hXX, exp_d[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
